// File: rtl/io_bridge_unit.sv
// Pad/LA bridge: input resynchronisation with per-channel glitch filtering and edge
// pulses, plus registered pad outputs and output-enables with LA override.
module io_bridge_unit #(
  parameter int                NUM_IN         = 4,
  parameter int                NUM_OUT        = 10,
  parameter int                SYNC_STAGES    = 2,
  parameter int                FILTER_WIDTH   = 4,
  parameter logic [NUM_IN-1:0]  IN_RESET_LEVEL = {NUM_IN{1'b1}},
  parameter logic [NUM_OUT-1:0] OEB_DEFAULT    = {NUM_OUT{1'b0}}
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       pad_in,
  input  logic [NUM_IN-1:0]       la_in_data,
  input  logic [NUM_IN-1:0]       la_in_oenb,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic [NUM_IN-1:0]       filter_bypass,
  output logic [NUM_IN-1:0]       in_level,
  output logic [NUM_IN-1:0]       in_rise,
  output logic [NUM_IN-1:0]       in_fall,
  input  logic [NUM_OUT-1:0]      core_out,
  input  logic [NUM_OUT-1:0]      la_out_data,
  input  logic [NUM_OUT-1:0]      la_out_oenb,
  input  logic [NUM_OUT-1:0]      la_oeb_data,
  input  logic [NUM_OUT-1:0]      la_oeb_oenb,
  output logic [NUM_OUT-1:0]      pad_out,
  output logic [NUM_OUT-1:0]      pad_oeb
);

  logic [NUM_IN-1:0]       src;
  logic [NUM_IN-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_IN-1:0]       sync_s;
  logic [FILTER_WIDTH-1:0] cnt_q  [NUM_IN];

  assign src    = (la_in_oenb & pad_in) | (~la_in_oenb & la_in_data);
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= IN_RESET_LEVEL;
      end
    end else begin
      sync_q[0] <= src;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
    end
  end

  // The counter only runs while the synchronised level disagrees with in_level, so any
  // mismatch that ends before reaching filter_len+1 cycles is simply forgotten.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_level <= IN_RESET_LEVEL;
      in_rise  <= '0;
      in_fall  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_rise[i] <= 1'b0;
        in_fall[i] <= 1'b0;
        if (filter_bypass[i]) begin
          in_level[i] <= sync_s[i];
          in_rise[i]  <= sync_s[i] & ~in_level[i];
          in_fall[i]  <= ~sync_s[i] & in_level[i];
          cnt_q[i]    <= '0;
        end else if (sync_s[i] == in_level[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= filter_len) begin
          in_level[i] <= sync_s[i];
          in_rise[i]  <= sync_s[i];
          in_fall[i]  <= ~sync_s[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + FILTER_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pad_out <= '0;
      pad_oeb <= OEB_DEFAULT;
    end else begin
      pad_out <= (la_out_oenb & core_out) | (~la_out_oenb & la_out_data);
      pad_oeb <= (la_oeb_oenb & OEB_DEFAULT) | (~la_oeb_oenb & la_oeb_data);
    end
  end

endmodule
